// File: rtl/mbus_ahb_master.sv
// MBUS node to AHB-Lite master bridge: one single-beat word transfer per node message.
// Optional read path with reply handshake is compiled in when MBUS_AHB_READ_EN is defined.
module mbus_ahb_master #(
    parameter logic [31:0] BASE_ADDR = 32'hA000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    // AHB-Lite master
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,
    // node RX side
    input  logic        REQ_RX,
    input  logic [7:0]  ADDR_IN,
    input  logic [31:0] DATA_IN,
    output logic        ACK_RX,
    // node TX side
    output logic        REQ_TX,
    output logic [7:0]  ADDR_OUT,
    output logic [31:0] DATA_OUT,
    input  logic        ACK_TX,
    output logic        ERR_INT
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
`ifdef MBUS_AHB_READ_EN
    localparam logic [2:0] ST_TX   = 3'd3;
`endif
    localparam logic [2:0] ST_ACK  = 3'd4;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic [2:0]  state;
    logic [31:0] msg_data;
    logic [31:0] wr_addr;

    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    // Node address selects a word offset from the base; any carry out of bit 31 is dropped.
    assign wr_addr = BASE_ADDR + {23'd0, ADDR_IN[6:0], 2'b00};

`ifdef MBUS_AHB_READ_EN
    logic [7:0] msg_addr;
`else
    assign REQ_TX   = 1'b0;
    assign ADDR_OUT = 8'd0;
    assign DATA_OUT = 32'd0;
    wire unused_rd = &{1'b0, ACK_TX, HRDATA};
`endif

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values;
    // the reset branch clears the latched message too, since a reset abandons it.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            HADDR    <= 32'd0;
            HTRANS   <= TRANS_IDLE;
            HWRITE   <= 1'b0;
            HWDATA   <= 32'd0;
            ACK_RX   <= 1'b0;
            ERR_INT  <= 1'b0;
            msg_data <= 32'd0;
`ifdef MBUS_AHB_READ_EN
            msg_addr <= 8'd0;
            REQ_TX   <= 1'b0;
            ADDR_OUT <= 8'd0;
            DATA_OUT <= 32'd0;
`endif
        end else begin
            ERR_INT <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ_RX && !ACK_RX) begin
                        msg_data <= DATA_IN;
`ifdef MBUS_AHB_READ_EN
                        msg_addr <= ADDR_IN;
                        state    <= ST_ADDR;
                        HTRANS   <= TRANS_NONSEQ;
                        if (ADDR_IN[7]) begin
                            HADDR  <= {DATA_IN[31:2], 2'b00};
                            HWRITE <= 1'b0;
                        end else begin
                            HADDR  <= wr_addr;
                            HWRITE <= 1'b1;
                        end
`else
                        if (ADDR_IN[7]) begin
                            // Reads are unsupported in this build: acknowledge without a bus cycle.
                            state  <= ST_ACK;
                            ACK_RX <= 1'b1;
                        end else begin
                            state  <= ST_ADDR;
                            HTRANS <= TRANS_NONSEQ;
                            HADDR  <= wr_addr;
                            HWRITE <= 1'b1;
                        end
`endif
                    end
                end

                ST_ADDR: begin
                    if (HREADY) begin
                        state  <= ST_DATA;
                        HTRANS <= TRANS_IDLE;
                        if (HWRITE) HWDATA <= msg_data;
                    end
                end

                ST_DATA: begin
                    if (HREADY) begin
                        if (HRESP) ERR_INT <= 1'b1;
`ifdef MBUS_AHB_READ_EN
                        if (!HWRITE) begin
                            state    <= ST_TX;
                            REQ_TX   <= 1'b1;
                            ADDR_OUT <= msg_addr;
                            DATA_OUT <= HRESP ? 32'hFFFF_FFFF : HRDATA;
                        end else begin
                            state  <= ST_ACK;
                            ACK_RX <= 1'b1;
                        end
`else
                        state  <= ST_ACK;
                        ACK_RX <= 1'b1;
`endif
                    end
                end

`ifdef MBUS_AHB_READ_EN
                ST_TX: begin
                    if (ACK_TX) begin
                        REQ_TX <= 1'b0;
                        state  <= ST_ACK;
                        ACK_RX <= 1'b1;
                    end
                end
`endif

                ST_ACK: begin
                    // Four-phase: REQ_RX held high here belongs to the message just acknowledged.
                    if (!REQ_RX) begin
                        ACK_RX <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
